// File: rtl/rv32_de_pipeline_reg.sv
// rv32_de_pipeline_reg: decode->execute pipeline register with stall, flush and illegal-instruction trap.
// Define RV32_DE_FPU_EN to carry rs3/rd3 and fp_reg_write for single-precision FP.
module rv32_de_pipeline_reg #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            d_valid_i,
   input  logic            d_valid_instr_i,
   input  logic [18:0]     d_ctrl_i,
   input  logic [XLEN-1:0] d_rd1_i,
   input  logic [XLEN-1:0] d_rd2_i,
   input  logic [XLEN-1:0] d_rd3_i,
   input  logic [XLEN-1:0] d_imm_i,
   input  logic [XLEN-1:0] d_pc_i,
   input  logic [XLEN-1:0] d_pc_plus4_i,
   input  logic [4:0]      d_rs1_i,
   input  logic [4:0]      d_rs2_i,
   input  logic [4:0]      d_rs3_i,
   input  logic [4:0]      d_rd_i,
   input  logic [2:0]      d_funct3_i,
   input  logic [6:0]      d_funct7_i,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic            e_valid_o,
   output logic [18:0]     e_ctrl_o,
   output logic [XLEN-1:0] e_rd1_o,
   output logic [XLEN-1:0] e_rd2_o,
   output logic [XLEN-1:0] e_rd3_o,
   output logic [XLEN-1:0] e_imm_o,
   output logic [XLEN-1:0] e_pc_o,
   output logic [XLEN-1:0] e_pc_plus4_o,
   output logic [4:0]      e_rs1_o,
   output logic [4:0]      e_rs2_o,
   output logic [4:0]      e_rs3_o,
   output logic [4:0]      e_rd_o,
   output logic [2:0]      e_funct3_o,
   output logic [6:0]      e_funct7_o,
   output logic            illegal_instr_o,
   output logic [XLEN-1:0] illegal_pc_o
);
   typedef enum logic [1:0] {BUBBLE, ACTIVE, HELD} state_t;
   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
   } data_t;

   state_t          state_q, state_d;
   data_t           data_q, data_d;
   logic [18:0]     ctrl_q, ctrl_d, ctrl_in;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] illegal_pc_q, illegal_pc_d;
   logic            fpu_bad, load, legal, take, illegal;

   always_comb begin
`ifdef RV32_DE_FPU_EN
      fpu_bad = 1'b0;
      ctrl_in = d_ctrl_i;
`else
      // FP opcodes (alu_op 4..8 or fp_reg_write) have no datapath without the FPU
      fpu_bad = d_ctrl_i[17] || (d_ctrl_i[5:2] >= 4'd4 && d_ctrl_i[5:2] <= 4'd8);
      ctrl_in = {d_ctrl_i[18], 1'b0, d_ctrl_i[16:0]};
`endif
      load    = !flush_i && !stall_i;
      legal   = d_valid_i && d_valid_instr_i && !fpu_bad;
      take    = load && legal;
      illegal = load && d_valid_i && !legal;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= BUBBLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = flush_i ? BUBBLE :
                stall_i ? (state_q == BUBBLE ? BUBBLE : HELD) :
                take    ? ACTIVE : BUBBLE;
   end

   always_comb begin
      e_valid_o = state_q != BUBBLE;
   end

   always_comb begin
      ctrl_d       = flush_i ? '0 : stall_i ? ctrl_q : take ? ctrl_in : '0;
      data_d       = take ? data_t'{d_rd1_i, d_rd2_i, d_imm_i, d_pc_i, d_pc_plus4_i,
                                    d_rs1_i, d_rs2_i, d_rd_i, d_funct3_i, d_funct7_i} : data_q;
      illegal_d    = illegal;
      illegal_pc_d = illegal ? d_pc_i : illegal_pc_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q       <= '0;
         data_q       <= '0;
         illegal_q    <= 1'b0;
         illegal_pc_q <= '0;
      end else begin
         ctrl_q       <= ctrl_d;
         data_q       <= data_d;
         illegal_q    <= illegal_d;
         illegal_pc_q <= illegal_pc_d;
      end
   end

`ifdef RV32_DE_FPU_EN
   logic [XLEN-1:0] rd3_q, rd3_d;
   logic [4:0]      rs3_q, rs3_d;

   always_comb begin
      rd3_d = take ? d_rd3_i : rd3_q;
      rs3_d = take ? d_rs3_i : rs3_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd3_q <= '0;
         rs3_q <= '0;
      end else begin
         rd3_q <= rd3_d;
         rs3_q <= rs3_d;
      end
   end

   assign e_rd3_o = rd3_q;
   assign e_rs3_o = rs3_q;
`else
   logic unused_fp;
   assign unused_fp = ^{d_rd3_i, d_rs3_i};
   assign e_rd3_o   = '0;
   assign e_rs3_o   = '0;
`endif

   assign e_ctrl_o        = ctrl_q;
   assign e_rd1_o         = data_q.rd1;
   assign e_rd2_o         = data_q.rd2;
   assign e_imm_o         = data_q.imm;
   assign e_pc_o          = data_q.pc;
   assign e_pc_plus4_o    = data_q.pc_plus4;
   assign e_rs1_o         = data_q.rs1;
   assign e_rs2_o         = data_q.rs2;
   assign e_rd_o          = data_q.rd;
   assign e_funct3_o      = data_q.funct3;
   assign e_funct7_o      = data_q.funct7;
   assign illegal_instr_o = illegal_q;
   assign illegal_pc_o    = illegal_pc_q;
endmodule

// File: tb/tb_rv32_de_pipeline_reg.sv
// tb_rv32_de_pipeline_reg: directed and randomized checks of the D/E pipeline register against a behavioural model.
module tb_rv32_de_pipeline_reg;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, dv, dvi, stall, flush;
   logic [18:0]     ctrl;
   logic [XLEN-1:0] rd1, rd2, rd3, imm, pc, pc4;
   logic [4:0]      rs1, rs2, rs3, rd;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic            e_valid, ill;
   logic [18:0]     e_ctrl;
   logic [XLEN-1:0] e_rd1, e_rd2, e_rd3, e_imm, e_pc, e_pc4, ill_pc;
   logic [4:0]      e_rs1, e_rs2, e_rs3, e_rd;
   logic [2:0]      e_f3;
   logic [6:0]      e_f7;

   rv32_de_pipeline_reg #(.XLEN(XLEN)) dut (
      .clk_i(clk), .rst_i(rst), .d_valid_i(dv), .d_valid_instr_i(dvi), .d_ctrl_i(ctrl),
      .d_rd1_i(rd1), .d_rd2_i(rd2), .d_rd3_i(rd3), .d_imm_i(imm), .d_pc_i(pc), .d_pc_plus4_i(pc4),
      .d_rs1_i(rs1), .d_rs2_i(rs2), .d_rs3_i(rs3), .d_rd_i(rd), .d_funct3_i(f3), .d_funct7_i(f7),
      .stall_i(stall), .flush_i(flush),
      .e_valid_o(e_valid), .e_ctrl_o(e_ctrl),
      .e_rd1_o(e_rd1), .e_rd2_o(e_rd2), .e_rd3_o(e_rd3), .e_imm_o(e_imm), .e_pc_o(e_pc), .e_pc_plus4_o(e_pc4),
      .e_rs1_o(e_rs1), .e_rs2_o(e_rs2), .e_rs3_o(e_rs3), .e_rd_o(e_rd), .e_funct3_o(e_f3), .e_funct7_o(e_f7),
      .illegal_instr_o(ill), .illegal_pc_o(ill_pc)
   );

   int total = 0, bad = 0;
   bit checking = 0;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
      end
   endtask

   function automatic bit fp_bad(input logic [18:0] c);
`ifdef RV32_DE_FPU_EN
      return 1'b0;
`else
      return c[17] || (c[5:2] inside {[4'd4:4'd8]});
`endif
   endfunction

   // reference model: what the execute stage must show after each edge
   logic            m_valid, m_ill;
   logic [18:0]     m_ctrl;
   logic [XLEN-1:0] m_rd1, m_rd2, m_rd3, m_imm, m_pc, m_pc4, m_ill_pc;
   logic [4:0]      m_rs1, m_rs2, m_rs3, m_rd;
   logic [2:0]      m_f3;
   logic [6:0]      m_f7;

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 0; m_ctrl <= 0; m_ill <= 0; m_ill_pc <= 0;
      end else begin
         m_ill <= 0;
         if (flush) begin
            m_valid <= 0; m_ctrl <= 0;
         end else if (!stall) begin
            if (dv && dvi && !fp_bad(ctrl)) begin
               m_valid <= 1;
`ifdef RV32_DE_FPU_EN
               m_ctrl <= ctrl; m_rd3 <= rd3; m_rs3 <= rs3;
`else
               m_ctrl <= ctrl & ~19'h20000; m_rd3 <= 0; m_rs3 <= 0;
`endif
               m_rd1 <= rd1; m_rd2 <= rd2; m_imm <= imm; m_pc <= pc; m_pc4 <= pc4;
               m_rs1 <= rs1; m_rs2 <= rs2; m_rd <= rd; m_f3 <= f3; m_f7 <= f7;
            end else begin
               m_valid <= 0; m_ctrl <= 0;
               if (dv) begin m_ill <= 1; m_ill_pc <= pc; end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("valid", e_valid, m_valid);
         chk("ctrl", e_ctrl, m_ctrl);
         chk("illegal", ill, m_ill);
         chk("illegal_pc", ill_pc, m_ill_pc);
         if (m_valid) begin
            chk("pc", e_pc, m_pc);     chk("pc4", e_pc4, m_pc4);
            chk("rd1", e_rd1, m_rd1);  chk("rd2", e_rd2, m_rd2);
            chk("rd3", e_rd3, m_rd3);  chk("imm", e_imm, m_imm);
            chk("rs1", e_rs1, m_rs1);  chk("rs2", e_rs2, m_rs2);
            chk("rs3", e_rs3, m_rs3);  chk("rd", e_rd, m_rd);
            chk("funct3", e_f3, m_f3); chk("funct7", e_f7, m_f7);
         end
      end
   end

   task automatic step(input logic v, input logic vi, input logic [18:0] c, input logic [XLEN-1:0] p,
                       input logic st, input logic fl);
      dv = v; dvi = vi; ctrl = c; pc = p; pc4 = p + 4; stall = st; flush = fl;
      rd1 = $urandom; rd2 = $urandom; rd3 = $urandom; imm = $urandom;
      rs1 = 5'($urandom); rs2 = 5'($urandom); rs3 = 5'($urandom); rd = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom);
      @(negedge clk);
   endtask

   localparam logic [18:0] ADDI = 19'h41008;
   localparam logic [18:0] FPOP = 19'h40014;

   initial begin
      rst = 1;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("rst_pc", e_pc, 0);
      chk("rst_rd1", e_rd1, 0);
      checking = 1;
      rst = 0;
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_valid", e_valid, 0);
      chk("post_rst_ctrl", e_ctrl, 0);
      chk("post_rst_ill", ill, 0);
      step(1, 1, ADDI, 32'h100, 0, 0);
      chk("addi_valid", e_valid, 1);
      chk("addi_pc", e_pc, 32'h100);
      chk("addi_ctrl", e_ctrl, ADDI);
      step(1, 1, ADDI, 32'h104, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 19'h1234 + 19'(i), 32'h108 + 32'(4 * i), 1, 0);
         chk("stall_pc", e_pc, 32'h104);
         chk("stall_valid", e_valid, 1);
      end
      step(1, 1, ADDI, 32'h110, 0, 0);
      chk("release_pc", e_pc, 32'h110);
      step(1, 1, ADDI, 32'h120, 1, 0);
      step(1, 1, ADDI, 32'h124, 1, 1);
      chk("stflush_valid", e_valid, 0);
      chk("stflush_ctrl", e_ctrl, 0);
      step(1, 0, ADDI, 32'h200, 0, 0);
      chk("ill_pulse", ill, 1);
      chk("ill_pc", ill_pc, 32'h200);
      chk("ill_valid", e_valid, 0);
      step(0, 0, 0, 32'h204, 0, 0);
      chk("ill_one_cycle", ill, 0);
      chk("ill_pc_hold", ill_pc, 32'h200);
      step(1, 0, ADDI, 32'h240, 1, 0);
      chk("ill_stall_nopulse", ill, 0);
      chk("ill_stall_pc", ill_pc, 32'h200);
      step(1, 1, FPOP, 32'h300, 0, 0);
`ifdef RV32_DE_FPU_EN
      chk("fp_valid", e_valid, 1);
      chk("fp_ctrl", e_ctrl, FPOP);
`else
      chk("fp_ill", ill, 1);
      chk("fp_ill_pc", ill_pc, 32'h300);
      chk("fp_valid", e_valid, 0);
`endif
      step(1, 1, ADDI, 32'h400, 0, 0);
      step(1, 1, ADDI, 32'h404, 1, 0);
      rst = 1;
      step(1, 0, ADDI, 32'h408, 1, 0);
      rst = 0;
      chk("rst_stall_valid", e_valid, 0);
      chk("rst_stall_ill", ill, 0);
      chk("rst_stall_ill_pc", ill_pc, 0);
      for (int i = 0; i < 3000; i++) begin
         logic [18:0] c;
         c = 19'($urandom);
         if ($urandom_range(0, 9) != 0) c[17] = 0;
         rst = $urandom_range(0, 49) == 0;
         step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9, c, $urandom,
              $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
